led_pattern_gen: RTL and testbench

Multi-channel LED pattern generator for board status indication. It is the parametrised successor to the single-output 1 Hz blink clock. It drives CH_NUM LED outputs from one shared millisecond tick. Each channel independently selects off, on, slow blink, fast blink or N-flash burst. All blinking channels stay phase-aligned. It sits between the status/fault logic and the LED pins.

---
 rtl/led_pattern_pkg.sv | 25 ++
 rtl/led_burst_fsm.sv | 98 +++++++++
 rtl/led_pattern_gen.sv | 130 +++++++++++++
 tb/tb_led_pattern_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared constants and types for the LED pattern generator and its burst FSMs.
package led_pattern_pkg;

    localparam int unsigned MODE_W    = 3;
    localparam int unsigned BURST_N_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ON    = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SLOW  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_FAST  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_BURST = 3'd4;

    typedef enum logic [1:0] {
        B_IDLE,
        B_ON,
        B_OFF,
        B_GAP
    } burst_state_t;

    // A requested flash count of zero still gives one flash per group.
    function automatic logic [BURST_N_W-1:0] burst_count(input logic [BURST_N_W-1:0] n);
        return (n == '0) ? BURST_N_W'(1) : n;
    endfunction

endpackage

// File: rtl/led_burst_fsm.sv
// One N-flash burst sequencer: ON/OFF flashes of FAST_HALF ticks, then a GAP_TICKS pause.
// led_nxt is the LED level for the state being entered, registered by the parent.
module led_burst_fsm
    import led_pattern_pkg::*;
#(
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned FAST_HALF = 125,
    parameter int unsigned GAP_TICKS = 1000
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 tick_en,
    input  logic                 sync_clr,
    input  logic                 active,
    input  logic [BURST_N_W-1:0] burst_n,
    output logic                 led_nxt
);

    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

    burst_state_t         state,     state_nxt;
    logic [CNT_W-1:0]     tick_cnt,  tick_nxt;
    logic [BURST_N_W-1:0] flash_cnt, flash_nxt;
    logic [BURST_N_W-1:0] n_q,       n_nxt;

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        flash_nxt = flash_cnt;
        n_nxt     = n_q;
        if (!active) begin
            state_nxt = B_IDLE;
            tick_nxt  = '0;
            flash_nxt = '0;
        end else if (state == B_IDLE || sync_clr) begin
            // Entry starts a flash at once; a realignment restarts the group but keeps its count.
            state_nxt = B_ON;
            tick_nxt  = '0;
            flash_nxt = '0;
            if (state == B_IDLE) begin
                n_nxt = burst_count(burst_n);
            end
        end else if (tick_en) begin
            case (state)
                B_ON: begin
                    if (tick_cnt == FAST_LAST) begin
                        tick_nxt  = '0;
                        state_nxt = B_OFF;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                B_OFF: begin
                    if (tick_cnt == FAST_LAST) begin
                        tick_nxt = '0;
                        if (flash_cnt == n_q - 3'd1) begin
                            flash_nxt = '0;
                            state_nxt = B_GAP;
                        end else begin
                            flash_nxt = flash_cnt + 1'b1;
                            state_nxt = B_ON;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                B_GAP: begin
                    if (tick_cnt == GAP_LAST) begin
                        tick_nxt  = '0;
                        state_nxt = B_ON;
                        n_nxt     = burst_count(burst_n);
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                default: state_nxt = B_IDLE;
            endcase
        end
    end

    assign led_nxt = (state_nxt == B_ON);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= B_IDLE;
            tick_cnt  <= '0;
            flash_cnt <= '0;
            n_q       <= BURST_N_W'(1);
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            flash_cnt <= flash_nxt;
            n_q       <= n_nxt;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared slow/fast blink timebases, per-channel mode mux.
// Define LED_BURST_EN to build the N-flash BURST mode; otherwise mode 4 blinks as SLOW.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned CH_NUM     = 4,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned SLOW_HALF  = 500,
    parameter int unsigned FAST_HALF  = 125,
    parameter int unsigned GAP_TICKS  = 1000,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        tick_en,
    input  logic                        sync_clr,
    input  logic [MODE_W*CH_NUM-1:0]    mode_i,
    input  logic [BURST_N_W*CH_NUM-1:0] burst_n_i,
    output logic [CH_NUM-1:0]           led_o
);

    if (CH_NUM < 1 || CH_NUM > 16) begin : g_bad_ch_num
        $error("led_pattern_gen: CH_NUM must be 1..16");
    end
    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
        $error("led_pattern_gen: CNT_W must be 1..31");
    end
    if (SLOW_HALF < 1 || SLOW_HALF >= (32'd1 << CNT_W)) begin : g_bad_slow
        $error("led_pattern_gen: SLOW_HALF does not fit CNT_W");
    end
    if (FAST_HALF < 1 || FAST_HALF >= (32'd1 << CNT_W)) begin : g_bad_fast
        $error("led_pattern_gen: FAST_HALF does not fit CNT_W");
    end
    if (GAP_TICKS < 1 || GAP_TICKS >= (32'd1 << CNT_W)) begin : g_bad_gap
        $error("led_pattern_gen: GAP_TICKS does not fit CNT_W");
    end

    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_HALF - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_HALF - 1);

    logic [CNT_W-1:0]  slow_cnt, slow_cnt_nxt;
    logic [CNT_W-1:0]  fast_cnt, fast_cnt_nxt;
    logic              slow_ph,  slow_ph_nxt;
    logic              fast_ph,  fast_ph_nxt;
    logic [CH_NUM-1:0] led_nxt;

    always_comb begin
        slow_cnt_nxt = slow_cnt;
        slow_ph_nxt  = slow_ph;
        fast_cnt_nxt = fast_cnt;
        fast_ph_nxt  = fast_ph;
        if (sync_clr) begin
            slow_cnt_nxt = '0;
            slow_ph_nxt  = 1'b0;
            fast_cnt_nxt = '0;
            fast_ph_nxt  = 1'b0;
        end else if (tick_en) begin
            if (slow_cnt == SLOW_LAST) begin
                slow_cnt_nxt = '0;
                slow_ph_nxt  = ~slow_ph;
            end else begin
                slow_cnt_nxt = slow_cnt + 1'b1;
            end
            if (fast_cnt == FAST_LAST) begin
                fast_cnt_nxt = '0;
                fast_ph_nxt  = ~fast_ph;
            end else begin
                fast_cnt_nxt = fast_cnt + 1'b1;
            end
        end
    end

`ifdef LED_BURST_EN
    logic [CH_NUM-1:0] burst_led;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_burst
        led_burst_fsm #(
            .CNT_W     (CNT_W),
            .FAST_HALF (FAST_HALF),
            .GAP_TICKS (GAP_TICKS)
        ) u_fsm (
            .clk      (clk),
            .nrst     (nrst),
            .tick_en  (tick_en),
            .sync_clr (sync_clr),
            .active   (mode_i[MODE_W*k +: MODE_W] == MODE_BURST),
            .burst_n  (burst_n_i[BURST_N_W*k +: BURST_N_W]),
            .led_nxt  (burst_led[k])
        );
    end
`else
    logic unused_burst_n;
    assign unused_burst_n = ^burst_n_i;
`endif

    // Muxing next-cycle phases lets led_o change on the same edge as the timebase.
    always_comb begin
        led_nxt = '0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            case (mode_i[MODE_W*k +: MODE_W])
                MODE_ON:    led_nxt[k] = 1'b1;
                MODE_SLOW:  led_nxt[k] = slow_ph_nxt;
                MODE_FAST:  led_nxt[k] = fast_ph_nxt;
`ifdef LED_BURST_EN
                MODE_BURST: led_nxt[k] = burst_led[k];
`else
                MODE_BURST: led_nxt[k] = slow_ph_nxt;
`endif
                default:    led_nxt[k] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            slow_cnt <= '0;
            fast_cnt <= '0;
            slow_ph  <= 1'b0;
            fast_ph  <= 1'b0;
            led_o    <= ACTIVE_LOW ? '1 : '0;
        end else begin
            slow_cnt <= slow_cnt_nxt;
            fast_cnt <= fast_cnt_nxt;
            slow_ph  <= slow_ph_nxt;
            fast_ph  <= fast_ph_nxt;
            led_o    <= led_nxt ^ {CH_NUM{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: constant vector table, hand sequences and a
// randomized run against a tick-counting reference model (both LED_BURST_EN builds).
module tb_led_pattern_gen;

    localparam int CH  = 4;
    localparam int SH  = 4;
    localparam int FH  = 2;
    localparam int GAP = 6;
`ifdef LED_BURST_EN
    localparam bit BURST_BUILD = 1'b1;
`else
    localparam bit BURST_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nrst;
    logic          tick_en;
    logic          sync_clr;
    logic [11:0]   mode;
    logic [11:0]   burst_n;
    logic [CH-1:0] led_a;
    logic [CH-1:0] led_b;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .CH_NUM(CH), .CNT_W(4), .SLOW_HALF(SH), .FAST_HALF(FH), .GAP_TICKS(GAP), .ACTIVE_LOW(1'b0)
    ) u_dut_hi (
        .clk(clk), .nrst(nrst), .tick_en(tick_en), .sync_clr(sync_clr),
        .mode_i(mode), .burst_n_i(burst_n), .led_o(led_a)
    );

    led_pattern_gen #(
        .CH_NUM(CH), .CNT_W(4), .SLOW_HALF(SH), .FAST_HALF(FH), .GAP_TICKS(GAP), .ACTIVE_LOW(1'b1)
    ) u_dut_lo (
        .clk(clk), .nrst(nrst), .tick_en(tick_en), .sync_clr(sync_clr),
        .mode_i(mode), .burst_n_i(burst_n), .led_o(led_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: tick counts since alignment, per-channel position within a burst group.
    int         slow_t, fast_t;
    int         pos [CH];
    int         nb  [CH];
    bit         was_act [CH];
    logic [3:0] exp_led;

    typedef struct {
        logic [11:0] mode;
        logic        tick;
        logic [3:0]  exp;
    } vec_t;
    vec_t tbl [6];

    function automatic logic [11:0] pack(input int m0, input int m1, input int m2, input int m3);
        return {3'(m3), 3'(m2), 3'(m1), 3'(m0)};
    endfunction

    function automatic int samp(input logic [2:0] n);
        return (n == 3'd0) ? 1 : int'(n);
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        slow_t  = 0;
        fast_t  = 0;
        exp_led = 4'b0000;
        for (int k = 0; k < CH; k++) begin
            pos[k] = 0;
            nb[k] = 1;
            was_act[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [2:0] m;
        logic [2:0] bn;
        int glen;
        if (sync_clr) begin
            slow_t = 0;
            fast_t = 0;
        end else if (tick_en) begin
            slow_t++;
            fast_t++;
        end
        for (int k = 0; k < CH; k++) begin
            m  = mode[3*k +: 3];
            bn = burst_n[3*k +: 3];
            if (BURST_BUILD && m == 3'd4) begin
                if (!was_act[k]) begin
                    pos[k] = 0;
                    nb[k]  = samp(bn);
                end else if (sync_clr) begin
                    pos[k] = 0;
                end else if (tick_en) begin
                    pos[k]++;
                    glen = 2 * nb[k] * FH + GAP;
                    if (pos[k] == glen) begin
                        pos[k] = 0;
                        nb[k]  = samp(bn);
                    end
                end
                was_act[k] = 1'b1;
                exp_led[k] = (pos[k] < 2 * nb[k] * FH) && ((pos[k] / FH) % 2 == 0);
            end else begin
                was_act[k] = 1'b0;
                case (m)
                    3'd1:    exp_led[k] = 1'b1;
                    3'd2:    exp_led[k] = ((slow_t / SH) % 2) == 1;
                    3'd3:    exp_led[k] = ((fast_t / FH) % 2) == 1;
                    3'd4:    exp_led[k] = ((slow_t / SH) % 2) == 1;
                    default: exp_led[k] = 1'b0;
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!nrst) model_reset();
        else model_edge();
        #1;
        check("model", led_a, exp_led);
        check("model_al", led_b, ~exp_led);
    endtask

    // Asynchronous assertion is checked before any clock edge, then one edge held in reset.
    task automatic do_reset();
        nrst = 1'b0;
        #1;
        check("async_rst", led_a, 4'b0000);
        check("async_rst_al", led_b, 4'b1111);
        @(posedge clk);
        model_reset();
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        logic [11:0] slowpat;
        logic [13:0] pat2;
        logic [9:0]  pat0;
        logic [1:0]  frozen;
        int          ch;

        slowpat = 12'b1000_0111_1000;
        pat2    = 14'b00000000110011;
        pat0    = 10'b0000000011;

        tbl[0] = '{pack(0, 1, 0, 1), 1'b1, 4'b1010};
        tbl[1] = '{pack(1, 1, 1, 1), 1'b1, 4'b1111};
        tbl[2] = '{pack(5, 6, 7, 1), 1'b1, 4'b1000};
        tbl[3] = '{pack(1, 6, 1, 0), 1'b0, 4'b0101};
        tbl[4] = '{pack(0, 0, 0, 0), 1'b1, 4'b0000};
        tbl[5] = '{pack(1, 1, 0, 0), 1'b0, 4'b0011};

        nrst     = 1'b0;
        tick_en  = 1'b1;
        sync_clr = 1'b0;
        mode     = '0;
        burst_n  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", led_a, 4'b0000);
        check("reset_al", led_b, 4'b1111);

        nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mode    = tbl[i].mode;
            tick_en = tbl[i].tick;
            step();
            check($sformatf("tbl%0d", i), led_a, tbl[i].exp);
            check($sformatf("tbl%0d_al", i), led_b, ~tbl[i].exp);
        end

        // Two SLOW channels from a fresh reset share one waveform.
        tick_en = 1'b1;
        do_reset();
        mode = pack(2, 2, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step();
            check("slow_ch0", {3'b0, led_a[0]}, {3'b0, slowpat[i]});
            check("slow_ch1", {3'b0, led_a[1]}, {3'b0, slowpat[i]});
        end

`ifdef LED_BURST_EN
        do_reset();
        burst_n = 12'(2) << 6;
        mode    = pack(0, 0, 4, 0);
        for (int i = 0; i < 28; i++) begin
            step();
            check("burst_n2", {3'b0, led_a[2]}, {3'b0, pat2[i % 14]});
        end
        mode = pack(0, 0, 0, 0);
        step();
        burst_n = '0;
        mode    = pack(0, 0, 4, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("burst_n0", {3'b0, led_a[2]}, {3'b0, pat0[i % 10]});
        end
`else
        do_reset();
        burst_n = '1;
        mode    = pack(0, 6, 4, 4);
        for (int i = 0; i < 12; i++) begin
            step();
            check("mode4_slow", {3'b0, led_a[3]}, {3'b0, slowpat[i]});
            check("reserved6", {3'b0, led_a[1]}, 4'b0000);
        end
`endif

        // Realignment in the middle of a slow half period.
        do_reset();
        burst_n = 12'(2) << 6;
        mode    = pack(2, 0, 4, 0);
        repeat (6) step();
        sync_clr = 1'b1;
        for (int j = 0; j < 12; j++) begin
            step();
            sync_clr = 1'b0;
            check("sync_slow", {3'b0, led_a[0]}, {3'b0, 1'((j / 4) % 2)});
`ifdef LED_BURST_EN
            check("sync_burst", {3'b0, led_a[2]}, {3'b0, pat2[j % 14]});
`else
            check("sync_mode4", {3'b0, led_a[2]}, {3'b0, 1'((j / 4) % 2)});
`endif
        end

        // Timebase freeze while static modes still follow in one clk.
        mode = pack(2, 3, 0, 0);
        repeat (5) step();
        tick_en = 1'b0;
        frozen  = exp_led[1:0];
        for (int i = 0; i < 20; i++) begin
            if (i == 5)  mode[11:9] = 3'd1;
            if (i == 12) mode[11:9] = 3'd0;
            step();
            check("freeze", {2'b0, led_a[1:0]}, {2'b0, frozen});
            check("freeze_ch3", {3'b0, led_a[3]}, {3'b0, 1'(i >= 5 && i < 12)});
        end
        tick_en = 1'b1;

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if ($urandom_range(7) == 0) begin
                ch = $urandom_range(3);
                mode[3*ch +: 3] = 3'($urandom_range(7));
            end
            if ($urandom_range(3) == 0) burst_n = 12'($urandom);
            tick_en  = ($urandom_range(3) != 0);
            sync_clr = ($urandom_range(31) == 0);
            step();
        end
        sync_clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
